piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of data bits per frame, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ins, input, WIDTH bits: parallel word to be serialized.
REQ-006 SHALL have port load_valid, input, 1 bit: ins holds a word offered for transmission.
REQ-007 SHALL have port load_ready, output, 1 bit: block accepts ins this cycle.
REQ-008 SHALL have port sout, output, 1 bit: serial data bit.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-010 SHALL have port frame_start, output, 1 bit: high only on the first bit of each frame.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT, plus PARITY when PISO_PARITY_EN is defined.
REQ-013 SHALL accept a word on the rising edge where load_valid=1 and load_ready=1, capturing ins into an internal WIDTH-bit shift register.
REQ-014 SHALL drive load_ready=1 in IDLE and during the final bit cycle of a frame; 0 otherwise; load_ready SHALL NOT depend combinationally on load_valid.
REQ-015 SHALL present the first frame bit on sout with sout_valid=1 and frame_start=1 in the cycle immediately after acceptance (latency 1 cycle).
REQ-016 SHALL present one bit per cycle for WIDTH consecutive cycles in SHIFT, ordered per MSB_FIRST, using a bit counter that counts 0..WIDTH-1 and does not wrap within a frame.
REQ-017 SHALL, on acceptance during the final bit cycle, start the next frame in the following cycle with no idle gap; frame_start SHALL pulse again.
REQ-018 SHALL, with no acceptance at the final bit cycle, return to IDLE; sout=0, sout_valid=0, frame_start=0 in IDLE.
REQ-019 SHALL ignore load_valid whenever load_ready=0; ins changes mid-frame SHALL NOT alter transmitted bits.
REQ-020 SHALL drive busy=1 in SHIFT and PARITY, 0 in IDLE.
REQ-021 SHALL register sout, sout_valid and frame_start (no combinational path from inputs).

Reset
REQ-022 SHALL, while rst_n=0, force IDLE, clear shift register and counter, and drive sout=0, sout_valid=0, frame_start=0, busy=0, load_ready=1.
REQ-023 SHALL abort any frame in progress when rst_n asserts mid-frame; no remaining bits are transmitted after rst_n deasserts.
REQ-024 SHALL accept a new word on the first rising edge after rst_n deasserts if load_valid=1.

Configuration
REQ-025 SHALL, when macro PISO_PARITY_EN is defined, append one even-parity bit (XOR of the WIDTH captured data bits) in a PARITY state after the last data bit, with sout_valid=1; the parity cycle is then the final bit cycle for REQ-014/REQ-017.
REQ-026 SHALL, without PISO_PARITY_EN, contain no PARITY state; frames are exactly WIDTH bits.

Verification
REQ-027 SHALL cover: WIDTH=4, MSB_FIRST=1, accept 1010 -> sout 1,0,1,0 on the next 4 cycles, frame_start on the first only, then IDLE.
REQ-028 SHALL cover: load_valid held high with 1100 then 0111 -> 8 contiguous valid bits 1,1,0,0,0,1,1,1, frame_start at bits 1 and 5, load_ready high only on bits 4 and 8.
REQ-029 SHALL cover: MSB_FIRST=0, accept 0001 -> sout 1,0,0,0.
REQ-030 SHALL cover: offer 1111 mid-frame while sending 0000 -> ignored, 0000 completes unaltered.
REQ-031 SHALL cover: rst_n low after 2nd bit of 1010 -> sout_valid=0 and busy=0 immediately, no further bits.
REQ-032 SHALL cover: PISO_PARITY_EN defined, accept 0111 -> sout 0,1,1,1,1 (parity 1) over 5 cycles; accept 0011 -> parity 0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out frame serializer with valid/ready load handshake.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ins,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_reg;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt_reg;
  logic             sout_reg;
  logic             sout_valid_reg;
  logic             frame_start_reg;
  logic             busy_reg;
  logic             load_ready_reg;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
`endif

  logic             ins_first;
  logic [WIDTH-1:0] ins_shifted;
  logic             shreg_next;
  logic [WIDTH-1:0] shreg_shifted;

  // The first bit goes straight to sout on acceptance, so the shift register
  // holds the remaining bits already aligned to the outgoing end.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign ins_first     = ins[WIDTH-1];
      assign ins_shifted   = {ins[WIDTH-2:0], 1'b0};
      assign shreg_next    = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign ins_first     = ins[0];
      assign ins_shifted   = {1'b0, ins[WIDTH-1:1]};
      assign shreg_next    = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shreg           <= '0;
      cnt_reg         <= '0;
      sout_reg        <= 1'b0;
      sout_valid_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      load_ready_reg  <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_reg      <= 1'b0;
`endif
    end else if (load_valid && load_ready_reg) begin
      state_reg       <= SHIFT;
      shreg           <= ins_shifted;
      cnt_reg         <= '0;
      sout_reg        <= ins_first;
      sout_valid_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
      busy_reg        <= 1'b1;
      load_ready_reg  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg      <= ^ins;
`endif
    end else begin
      frame_start_reg <= 1'b0;
      case (state_reg)
        SHIFT: begin
          if (cnt_reg == LAST) begin
`ifdef PISO_PARITY_EN
            state_reg      <= PARITY;
            sout_reg       <= parity_reg;
            load_ready_reg <= 1'b1;
`else
            state_reg      <= IDLE;
            sout_reg       <= 1'b0;
            sout_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            load_ready_reg <= 1'b1;
`endif
          end else begin
            cnt_reg  <= cnt_reg + CW'(1);
            sout_reg <= shreg_next;
            shreg    <= shreg_shifted;
`ifndef PISO_PARITY_EN
            // Ready rises one cycle early so it is high during the last bit.
            load_ready_reg <= (cnt_reg == PENULT);
`endif
          end
        end
        default: begin
          state_reg      <= IDLE;
          sout_reg       <= 1'b0;
          sout_valid_reg <= 1'b0;
          busy_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready  = load_ready_reg;
  assign sout        = sout_reg;
  assign sout_valid  = sout_valid_reg;
  assign frame_start = frame_start_reg;
  assign busy        = busy_reg;

endmodule
